dmem_handshake: RTL and testbench

Parametrised data memory for the RV32I multi-cycle core, replacing the fixed 16 KB word-only RAM. Adds a valid/ready request handshake, a configurable wait-state count, and byte/halfword/word accesses with lane steering and load sign-extension. It also flags misaligned and out-of-range accesses. It sits between the core's memory-stage FSM and the testbench-preloaded storage array.

---
 rtl/dmem_handshake.sv | 243 ++++++++++++++++++++++++
 tb/tb_dmem_handshake.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_handshake.sv
// dmem_handshake
// ---------------------------------------------------------------------------
// Parametrised data memory for the RV32I multi-cycle core. A request is
// accepted with a valid/ready handshake. After LATENCY wait-state cycles,
// one response pulse is issued. Byte, halfword and word accesses are
// supported, with lane steering on stores and sign/zero extension on loads.
// Out-of-range addresses and illegal sizes fault.
//
// Optional feature (compile-time macro DMEM_MISALIGN_TRAP_EN):
//   defined     : misaligned half/word accesses fault (no write, rdata = 0)
//   not defined : misaligned accesses are force-aligned and proceed normally
//
// Parameters
//   ADDR_W       byte-address bits decoded (depth = 2^(ADDR_W-2) words)
//   LATENCY      wait-state cycles between accept and response (0..15)
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_ready    block can accept a request (IDLE and not in reset)
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_wdata    right-aligned store data
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   resp_valid   one-cycle response pulse
//   resp_rdata   extended load data, 0 for stores and faults (held)
//   resp_err     access faulted, qualified by resp_valid (held)
// ---------------------------------------------------------------------------
module dmem_handshake #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    // Storage is deliberately not reset; it is preloaded from outside.
    logic [31:0] ram [0:DEPTH-1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [1:0]        cur_size;
    logic              cur_unsigned;
    logic [31:0]       eff_addr;
    logic              access_err;
    logic              go_resp;
    logic              wr_en;
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       lane_word;
    logic [31:0]       load_data;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_rep;

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // The request being serviced: with LATENCY=0 the response is produced on
    // the accept edge itself, so the live inputs must be used while IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we       = req_we;
            cur_addr     = req_addr;
            cur_wdata    = req_wdata;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
        end else begin
            cur_we       = we_q;
            cur_addr     = addr_q;
            cur_wdata    = wdata_q;
            cur_size     = size_q;
            cur_unsigned = unsigned_q;
        end
    end

    // Fault detection and effective (possibly force-aligned) address.
    always_comb begin
        access_err = ((cur_addr >> ADDR_W) != 32'd0) || (cur_size == 2'b11);
        eff_addr   = cur_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((cur_size == 2'b01 && cur_addr[0]) ||
            (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)) begin
            access_err = 1'b1;
        end
`else
        if (cur_size == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (cur_size == 2'b10) begin
            eff_addr[1:0] = 2'b00;
        end
`endif
    end

    // Lane steering for stores and lane extraction/extension for loads.
    // Shifting the word down by the byte offset puts the selected byte or
    // halfword at bit 0 for either size.
    always_comb begin
        word_idx  = eff_addr[ADDR_W-1:2];
        rd_word   = ram[word_idx];
        lane_word = rd_word >> {eff_addr[1:0], 3'b000};
        byte_en   = 4'b0000;
        wdata_rep = cur_wdata;
        load_data = rd_word;
        case (cur_size)
            2'b00: begin
                byte_en   = 4'b0001 << eff_addr[1:0];
                wdata_rep = {4{cur_wdata[7:0]}};
                load_data = cur_unsigned ? {24'd0, lane_word[7:0]}
                                         : {{24{lane_word[7]}}, lane_word[7:0]};
            end
            2'b01: begin
                byte_en   = eff_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cur_wdata[15:0]}};
                load_data = cur_unsigned ? {16'd0, lane_word[15:0]}
                                         : {{16{lane_word[15]}}, lane_word[15:0]};
            end
            2'b10: begin
                byte_en = 4'b1111;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

    // Next-state logic: handshake FSM, wait counter, request capture and
    // the registered response fields.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        go_resp      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    cnt_d      = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    go_resp = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (go_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = access_err;
            resp_rdata_d = (access_err || cur_we) ? 32'd0 : load_data;
        end
    end

    // Reset wins over a commit on the same edge, so an aborted store is lost.
    assign wr_en = go_resp && cur_we && !access_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    ram[word_idx][8*k +: 8] <= wdata_rep[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_handshake.sv
// tb_dmem_handshake
// ---------------------------------------------------------------------------
// Self-checking bench for dmem_handshake. Two instances share one set of
// request inputs: dut_l2 (LATENCY=2) and dut_l0 (LATENCY=0); 'sel' chooses
// which one sees req_valid and whose outputs are observed. Expected values
// come from a byte-addressed reference memory that applies the access rules
// directly (size in bytes, alignment, range, extension).
// ---------------------------------------------------------------------------
module tb_dmem_handshake;

    localparam int ADDR_W   = 14;
    localparam int NBYTES   = 1 << ADDR_W;
    localparam int NWORDS   = NBYTES / 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;

    logic        valid_l2, valid_l0;
    logic        ready_l2, ready_l0;
    logic        rvalid_l2, rvalid_l0;
    logic [31:0] rdata_l2, rdata_l0;
    logic        err_l2, err_l0;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] mem [2][NBYTES];

    always #5 clk = ~clk;

    assign valid_l2 = req_valid & ~sel;
    assign valid_l0 = req_valid & sel;
    assign o_ready  = sel ? ready_l0  : ready_l2;
    assign o_valid  = sel ? rvalid_l0 : rvalid_l2;
    assign o_rdata  = sel ? rdata_l0  : rdata_l2;
    assign o_err    = sel ? err_l0    : err_l2;

    dmem_handshake #(.ADDR_W(ADDR_W), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .req_valid(valid_l2), .req_ready(ready_l2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(rvalid_l2), .resp_rdata(rdata_l2), .resp_err(err_l2)
    );

    dmem_handshake #(.ADDR_W(ADDR_W), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst), .req_valid(valid_l0), .req_ready(ready_l0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(rvalid_l0), .resp_rdata(rdata_l0), .resp_err(err_l0)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: operates on bytes, independent of word/lane layout.
    task automatic model_access(input int s, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, output logic [31:0] rdata, output logic err);
        int unsigned n;
        int unsigned a;
        logic [31:0] v;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a   = addr;
        err = (a >= NBYTES) || (size == 2'd3);
        if (!err && (a % n) != 0) begin
            if (TRAP) err = 1'b1;
            else      a = a - (a % n);
        end
        rdata = 32'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < int'(n); i++) mem[s][a + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < int'(n); i++) v = v | (32'(mem[s][a + i]) << (8 * i));
            if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
            rdata = v;
        end
    endtask

    // One complete transaction with cycle-exact checks of the handshake.
    task automatic apply_stimulus(input logic s, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] size,
                                  input logic uns);
        logic [31:0] exp_data;
        logic        exp_err;
        int          lat;
        sel = s;
        lat = s ? 0 : 2;
        model_access(int'(s), we, addr, wdata, size, uns, exp_data, exp_err);
        @(negedge clk);
        check_output("ready_idle", 32'(o_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom_range(0, 3));
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check_output("wait_valid", 32'(o_valid), 32'd0);
            check_output("wait_ready", 32'(o_ready), 32'd0);
        end
        @(negedge clk);
        check_output("resp_valid", 32'(o_valid), 32'd1);
        check_output("resp_ready", 32'(o_ready), 32'd0);
        check_output("resp_rdata", o_rdata, exp_data);
        check_output("resp_err", 32'(o_err), 32'(exp_err));
        @(negedge clk);
        check_output("post_valid", 32'(o_valid), 32'd0);
        check_output("post_ready", 32'(o_ready), 32'd1);
        check_output("hold_rdata", o_rdata, exp_data);
    endtask

    task automatic random_access(input logic s);
        logic [31:0] a;
        logic [1:0]  sz;
        a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        apply_stimulus(s, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < NWORDS; i++) begin
            w = $urandom;
            dut_l2.ram[i] = w;
            for (int k = 0; k < 4; k++) mem[0][4*i + k] = w[8*k +: 8];
            w = $urandom;
            dut_l0.ram[i] = w;
            for (int k = 0; k < 4; k++) mem[1][4*i + k] = w[8*k +: 8];
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #0;
            check_output("rst_ready", 32'(o_ready), 32'd0);
            check_output("rst_valid", 32'(o_valid), 32'd0);
            check_output("rst_rdata", o_rdata, 32'd0);
            check_output("rst_err", 32'(o_err), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_output("ready_after_rst_l2", 32'(ready_l2), 32'd1);
        check_output("ready_after_rst_l0", 32'(ready_l0), 32'd1);

        // Directed sequence, LATENCY=2 instance
        apply_stimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h11, 32'h0000_01A5, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h11, 32'h0, 2'd0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h12, 32'h0000_8001, 2'd1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h13, 32'h0, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h13, 32'hCAFE_F00D, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h4000, 32'h1111_2222, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h8, 32'h0, 2'd3, 1'b0);

        // LATENCY=0 instance, directed then random
        apply_stimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
        apply_stimulus(1'b1, 1'b1, 32'h11, 32'h0000_01A5, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h13, 32'h0, 2'd1, 1'b1);
        for (int i = 0; i < 60; i++) random_access(1'b1);

        // Random traffic on the LATENCY=2 instance
        for (int i = 0; i < 60; i++) random_access(1'b0);

        // Reset during the second WAIT cycle discards the pending store
        sel = 1'b0;
        @(negedge clk);
        check_output("abort_ready", 32'(o_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_size  = 2'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_output("abort_wait1_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        check_output("abort_wait2_valid", 32'(o_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_rst_valid", 32'(o_valid), 32'd0);
        check_output("abort_rst_ready", 32'(o_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("abort_post_valid", 32'(o_valid), 32'd0);
        check_output("abort_post_ready", 32'(o_ready), 32'd1);
        check_output("abort_post_rdata", o_rdata, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
